led_ctrl: RTL and testbench
===========================

# led_ctrl

Parametrised multi-channel LED controller with a shared prescaler. It is the successor to the single fixed-rate blinker. It sits in the PLL `clk` domain next to the board top level and drives NUM_CH LED pins. Each channel is independently configurable through a single-cycle write port as OFF, ON, BLINK (programmable half-period in ticks) or PWM (programmable duty).

## Interface
Parameters:
- CLK_DIV, 4000: clk cycles per tick (4000 gives a 100 µs tick at 40 MHz); must be ≥ 2.
- NUM_CH, 4: number of LED channels; must be ≥ 1.
- CNT_W, 16: width of the per-channel BLINK period counter.
- PWM_W, 8: width of the PWM counter and duty.

Ports:
- clk, in, 1: sole clock; all logic is on its rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- cfg_we, in, 1: configuration write strobe, one cycle.
- cfg_ch, in, CH_W = max(1,$clog2(NUM_CH)): target channel.
- cfg_mode, in, 2: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
- cfg_period, in, CNT_W: BLINK half-period minus one, in ticks; also the breathe step interval.
- cfg_duty, in, PWM_W: PWM on-count (static duty, or breathe ceiling).
- tick_o, out, 1: one-cycle pulse at each prescaler wrap.
- led, out, NUM_CH: registered LED drive, active-high.

## Operation
- Prescaler `div_cnt` counts 0..CLK_DIV-1 and then wraps. `tick` is asserted in the cycle where `div_cnt == CLK_DIV-1`. tick_o is registered, so it lags `tick` by 1 clk.
- PWM counter `pwm_cnt` (PWM_W bits) increments every clk and wraps naturally at 2^PWM_W. It is shared by all channels.
- Per channel, the block stores: mode (2 bits), period (CNT_W bits), duty (PWM_W bits), tick counter `t_cnt` (CNT_W bits), `blink_q`, and `cur_duty` (PWM_W bits).
- Write behaviour:
  - A write with `cfg_we=1` and `cfg_ch<NUM_CH` loads mode, period and duty for that channel.
  - The same write clears `t_cnt`, `blink_q` and `cur_duty`.
  - A write with `cfg_ch≥NUM_CH` is ignored.
- Channel behaviour by mode:
  - OFF: led=0.
  - ON: led=1.
  - BLINK: on each tick, if `t_cnt==period`, then `t_cnt<=0` and `blink_q` toggles; otherwise `t_cnt` increments. led=`blink_q`. A period of 0 toggles on every tick.
  - PWM: led = (`pwm_cnt < cur_duty`). In static mode `cur_duty` is set to `duty` on the cycle after the write. duty=0 gives led always 0. duty=2^PWM_W-1 gives led 1 for 255 of every 256 cycles.
- Simultaneous tick and write to the same channel: the write wins. Counters are cleared and that tick is not counted. Other channels process the tick normally.
- Reset mid-operation: all state returns to its reset values on the next edge; any in-progress blink phase is discarded.

## Timing
- Reset values: led=0, tick_o=0, div_cnt=0, pwm_cnt=0, all modes OFF, all period, duty, t_cnt, blink_q and cur_duty = 0.
- The first tick occurs CLK_DIV cycles after rst_n deasserts. tick_o is high in cycle CLK_DIV+1.
- Write to led latency:
  - Write at edge N; registered state updates at N.
  - led reflects the new mode at edge N+1.
  - In BLINK mode the first toggle happens on the (period+1)-th tick after the write.
- led is a pure register output with no combinational path from inputs.

## Configuration
- LED_BREATHE_EN defined:
  - In PWM mode `cur_duty` ramps instead of holding static.
  - Each time the channel's `t_cnt` reaches period on a tick, `cur_duty` steps by ±1.
  - The ramp starts from 0 going up. On reaching `duty` the direction flips to down; on reaching 0 it flips to up.
  - Per channel this adds a 1-bit direction register, reset to up.
  - duty=0 holds at 0.
- LED_BREATHE_EN undefined: PWM duty is static as described in Operation. No direction register and no ramp logic are synthesised.

## Structure
- Package `led_ctrl_pkg`: mode encoding constants MODE_OFF=2'd0, MODE_ON=2'd1, MODE_BLINK=2'd2, MODE_PWM=2'd3, and the default CLK_DIV value.
- Sub-module `led_ctrl_ch`: one channel's registers, blink and breathe logic, and its output flop. It is instantiated NUM_CH times via generate. The prescaler and PWM counter live in the top level.

## Test plan
All scenarios use CLK_DIV=4 and NUM_CH=4.
- Reset release: hold rst_n=0 for 3 cycles, then release → led=4'b0000 throughout; tick_o pulses at cycles 5, 9, 13 after release.
- BLINK: write ch1 mode=2, period=2 → led[1] toggles every 3 ticks (12 clk); other channels stay 0.
- ON/OFF plus invalid write: write ch0 ON → led[0]=1 one cycle later. Write cfg_ch=5 (CH_W=2 cannot encode it) or ch≥NUM_CH with NUM_CH=3 → no state change. Write ch0 OFF → led[0]=0 next cycle.
- PWM static: write ch2 mode=3, duty=64 → led[2] high for exactly 64 of every 256 cycles. With duty=0 → never high.
- Collision: issue a write to ch1 in the same cycle as a tick → t_cnt[1]=0 afterwards and the next toggle comes (period+1) ticks later. Ch3, in BLINK with period=0, still toggles on that tick.
- LED_BREATHE_EN: ch3 mode=3, period=0, duty=3 → cur_duty steps through 0,1,2,3,2,1,0,1 on successive ticks.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared constants for the multi-channel LED controller.
//   MODE_*          : per-channel mode encoding carried on cfg_mode
//   CLK_DIV_DEFAULT : default prescaler ratio (100 us tick at 40 MHz)
package led_ctrl_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 4000;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PWM   = 2'd3;

endpackage

// File: rtl/led_ctrl_ch.sv
// led_ctrl_ch: one LED channel (config registers, blink/breathe logic, output flop).
// Optional feature macro: LED_BREATHE_EN (PWM duty ramps up/down instead of holding static).
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   we_i         : write strobe already decoded for this channel
//   mode_i       : new mode (MODE_OFF/ON/BLINK/PWM)
//   period_i     : BLINK half-period minus one in ticks (also breathe step interval)
//   duty_i       : PWM on-count (static duty or breathe ceiling)
//   tick_i       : shared prescaler tick
//   pwm_cnt_i    : shared free-running PWM counter
//   led_o        : registered LED drive
module led_ctrl_ch
    import led_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [PWM_W-1:0] duty_i,
    input  logic             tick_i,
    input  logic [PWM_W-1:0] pwm_cnt_i,
    output logic             led_o
);

    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] t_cnt_q, t_cnt_d;
    logic             blink_q, blink_d;
    logic [PWM_W-1:0] cur_duty_q, cur_duty_d;
    logic             led_q, led_d;
    logic             wrap;
`ifdef LED_BREATHE_EN
    logic             dir_q, dir_d;  // 1: ramping up
`endif

    assign wrap = tick_i && (t_cnt_q == period_q);

    always_comb begin
        mode_d     = mode_q;
        period_d   = period_q;
        duty_d     = duty_q;
        t_cnt_d    = t_cnt_q;
        blink_d    = blink_q;
        cur_duty_d = cur_duty_q;
`ifdef LED_BREATHE_EN
        dir_d      = dir_q;
`endif
        // A write takes priority over a coincident tick; that tick is dropped.
        if (we_i) begin
            mode_d     = mode_i;
            period_d   = period_i;
            duty_d     = duty_i;
            t_cnt_d    = '0;
            blink_d    = 1'b0;
            cur_duty_d = '0;
`ifdef LED_BREATHE_EN
            dir_d      = 1'b1;
`endif
        end else begin
            if (tick_i && (mode_q == MODE_BLINK || mode_q == MODE_PWM)) begin
                t_cnt_d = wrap ? '0 : t_cnt_q + CNT_W'(1);
            end
            if (mode_q == MODE_BLINK && wrap) begin
                blink_d = ~blink_q;
            end
`ifdef LED_BREATHE_EN
            if (mode_q == MODE_PWM && wrap) begin
                if (duty_q == '0) begin
                    cur_duty_d = '0;
                end else if (dir_q) begin
                    cur_duty_d = cur_duty_q + PWM_W'(1);
                    if (cur_duty_d == duty_q) dir_d = 1'b0;
                end else begin
                    cur_duty_d = cur_duty_q - PWM_W'(1);
                    if (cur_duty_d == '0) dir_d = 1'b1;
                end
            end
`else
            if (mode_q == MODE_PWM) begin
                cur_duty_d = duty_q;
            end
`endif
        end
    end

    always_comb begin
        led_d = 1'b0;
        unique case (mode_q)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = blink_q;
            MODE_PWM:   led_d = (pwm_cnt_i < cur_duty_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= MODE_OFF;
            period_q   <= '0;
            duty_q     <= '0;
            t_cnt_q    <= '0;
            blink_q    <= 1'b0;
            cur_duty_q <= '0;
            led_q      <= 1'b0;
`ifdef LED_BREATHE_EN
            dir_q      <= 1'b1;
`endif
        end else begin
            mode_q     <= mode_d;
            period_q   <= period_d;
            duty_q     <= duty_d;
            t_cnt_q    <= t_cnt_d;
            blink_q    <= blink_d;
            cur_duty_q <= cur_duty_d;
            led_q      <= led_d;
`ifdef LED_BREATHE_EN
            dir_q      <= dir_d;
`endif
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_ctrl.sv
// led_ctrl: multi-channel LED controller with a shared prescaler and PWM counter.
// Optional feature macro: LED_BREATHE_EN (breathing PWM, implemented in led_ctrl_ch).
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   cfg_we      : one-cycle configuration write strobe
//   cfg_ch      : target channel; values >= NUM_CH are ignored
//   cfg_mode    : 0 OFF, 1 ON, 2 BLINK, 3 PWM
//   cfg_period  : BLINK half-period minus one in ticks
//   cfg_duty    : PWM on-count
//   tick_o      : registered one-cycle pulse per prescaler wrap
//   led         : registered LED outputs, active-high
module led_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned PWM_W   = 8,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [PWM_W-1:0]  cfg_duty,
    output logic              tick_o,
    output logic [NUM_CH-1:0] led
);

    localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic             tick;
    logic             tick_q;

    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            pwm_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            tick_q    <= tick;
        end
    end

    assign tick_o = tick_q;

    // Out-of-range cfg_ch matches no channel, so such writes fall through.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_ctrl_ch #(
            .CNT_W (CNT_W),
            .PWM_W (PWM_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .we_i      (cfg_we && (cfg_ch == CH_W'(i))),
            .mode_i    (cfg_mode),
            .period_i  (cfg_period),
            .duty_i    (cfg_duty),
            .tick_i    (tick),
            .pwm_cnt_i (pwm_cnt_q),
            .led_o     (led[i])
        );
    end

endmodule

// File: tb/tb_led_ctrl.sv
module tb_led_ctrl;
    import led_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_period = '0;
    logic [7:0]  cfg_duty = '0;
    logic        tick_o, tick3;
    logic [3:0]  led;
    logic [2:0]  led3;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    string       tag_q[$];
    logic [31:0] val_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= rst_n ? edge_n + 1 : 0;

    led_ctrl #(.CLK_DIV(4), .NUM_CH(4), .CNT_W(16), .PWM_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_period(cfg_period), .cfg_duty(cfg_duty), .tick_o(tick_o), .led(led)
    );

    // Three-channel copy: cfg_ch=3 is out of range here and must be ignored.
    led_ctrl #(.CLK_DIV(4), .NUM_CH(3), .CNT_W(16), .PWM_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_period(cfg_period), .cfg_duty(cfg_duty), .tick_o(tick3), .led(led3)
    );

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (val_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
            return;
        end
        t = tag_q.pop_front();
        e = val_q.pop_front();
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
        end
    endtask

    // Drive a write so that it is captured by the next edge with edge_n % 4 == m.
    task automatic cfg_write(input int m, input int ch, input logic [1:0] mode,
                             input int period, input int duty);
        while (((edge_n + 1) % 4) != m) step();
        cfg_we = 1'b1;
        cfg_ch = 2'(ch);
        cfg_mode = mode;
        cfg_period = 16'(period);
        cfg_duty = 8'(duty);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic led_at(input int target, input logic [3:0] exp, input string tag);
        while (edge_n < target) step();
        push(tag, 32'(exp));
        check(32'(led));
    endtask

    int w, w1, cnt;

    initial begin
        // Reset
        repeat (3) step();
        push("rst_led", 0);  check(32'(led));
        push("rst_tick", 0); check(32'(tick_o));
        push("rst_led3", 0); check(32'(led3));
        rst_n = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            step();
            push("tick_o", 32'(e % 4 == 0)); check(32'(tick_o));
            push("led_idle", 0);             check(32'(led));
        end

        // ON / invalid channel / OFF
        cfg_write(2, 0, MODE_ON, 0, 0);
        push("on_latency", 0);   check(32'(led));
        step();
        push("on", 4'b0001);     check(32'(led));
        push("on3", 3'b001);     check(32'(led3));
        cfg_write(2, 3, MODE_ON, 0, 0);
        step();
        push("ch3_on", 4'b1001); check(32'(led));
        push("ch3_ignored", 3'b001); check(32'(led3));
        cfg_write(2, 3, MODE_OFF, 0, 0);
        step();
        push("ch3_off", 4'b0001); check(32'(led));
        cfg_write(2, 0, MODE_OFF, 0, 0);
        step();
        push("off", 4'b0000);    check(32'(led));
        push("off3", 3'b000);    check(32'(led3));

        // BLINK ch1 period=2: write right after a tick, third tick toggles
        cfg_write(1, 1, MODE_BLINK, 2, 0);
        w = edge_n;
        led_at(w + 11, 4'b0000, "blink_pre");
        led_at(w + 12, 4'b0010, "blink_rise");
        led_at(w + 23, 4'b0010, "blink_hold");
        led_at(w + 24, 4'b0000, "blink_fall");

        // Collision: ch3 BLINK period=0, then ch1 rewritten on a tick edge
        cfg_write(1, 3, MODE_BLINK, 0, 0);
        cfg_write(0, 1, MODE_BLINK, 2, 0);
        w1 = edge_n;
        led_at(w1,      4'b0000, "coll_w");
        led_at(w1 + 1,  4'b1000, "coll_ch3_toggles");
        led_at(w1 + 5,  4'b0000, "coll_ch3_next");
        led_at(w1 + 9,  4'b1000, "coll_ch1_not_early");
        led_at(w1 + 12, 4'b1000, "coll_ch1_pre");
        led_at(w1 + 13, 4'b0010, "coll_ch1_toggle");

        // Reset mid-operation discards blink state
        rst_n = 1'b0;
        step();
        push("midrst_led", 0);  check(32'(led));
        push("midrst_tick", 0); check(32'(tick_o));
        rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            push("midrst_idle", 0); check(32'(led));
        end
        push("midrst_tick_again", 1); check(32'(32'(edge_n % 4 == 0) & 32'(tick_o)));

`ifndef LED_BREATHE_EN
        // PWM static duty
        cfg_write(1, 2, MODE_PWM, 0, 64);
        step(); step();
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (led[2]) cnt++;
        end
        push("pwm64", 64); check(32'(cnt));
        cfg_write(1, 2, MODE_PWM, 0, 255);
        step(); step();
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (led[2]) cnt++;
        end
        push("pwm255", 255); check(32'(cnt));
        cfg_write(1, 2, MODE_PWM, 0, 0);
        step(); step();
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (led != 4'b0000) cnt++;
        end
        push("pwm0", 0); check(32'(cnt));
`else
        // Breathe: ch3 period=0 duty=3 steps once per tick
        cfg_write(1, 3, MODE_PWM, 0, 3);
        w = edge_n;
        push("breathe_0", 0); check(32'(dut.g_ch[3].u_ch.cur_duty_q));
        for (int k = 1; k <= 7; k++) begin
            int exp_d;
            exp_d = (k <= 3) ? k : ((k <= 6) ? 6 - k : k - 6);
            while (edge_n < w + 4 * k - 1) step();
            push("breathe_step", 32'(exp_d));
            check(32'(dut.g_ch[3].u_ch.cur_duty_q));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
